// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus width, count-direction encoding and the
// MAX_VALUE range check used when elaborating bus counters.
package cpu_pkg;

   localparam int unsigned DEFAULT_DATA_WIDTH = 8;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // True when max_value fits in a register of the given width.
   function automatic bit max_value_ok(input int unsigned width, input longint unsigned max_value);
      if (width == 0 || width > 63) return 1'b0;
      return max_value < (64'(1) << width);
   endfunction

endpackage

// File: rtl/updown_next.sv
// Next-count and terminal-count logic for updown_counter.
// Build macro UPDOWN_COUNTER_SAT_EN: saturate at the range ends instead of wrapping.
module updown_next
   import cpu_pkg::*;
#(
   parameter int unsigned     DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter longint unsigned MAX_VALUE  = (64'(1) << DATA_WIDTH) - 64'(1)
) (
   input  logic [DATA_WIDTH-1:0] count,
   input  logic                  up,
   input  logic                  cnt_en,
   output logic [DATA_WIDTH-1:0] next_c,
   output logic                  carry_c
);

`ifdef UPDOWN_COUNTER_SAT_EN
   localparam bit SATURATE = 1'b1;
`else
   localparam bit SATURATE = 1'b0;
`endif

   localparam logic [DATA_WIDTH-1:0] TOP = DATA_WIDTH'(MAX_VALUE);

   logic at_top;
   logic at_bottom;

   // A loaded value above TOP counts as being at the top of the range.
   assign at_top    = (count >= TOP);
   assign at_bottom = (count == '0);

   always_comb begin
      next_c  = count;
      carry_c = 1'b0;
      if (cnt_en) begin
         if (up == DIR_UP) begin
            carry_c = at_top;
            if (!at_top) begin
               next_c = count + DATA_WIDTH'(1);
            end else if (!SATURATE) begin
               next_c = '0;
            end
         end else begin
            carry_c = at_bottom;
            if (!at_bottom) begin
               next_c = count - DATA_WIDTH'(1);
            end else if (!SATURATE) begin
               next_c = TOP;
            end
         end
      end
   end

endmodule

// File: rtl/updown_counter.sv
// Loadable up/down bus counter with programmable modulus and cascadable CARRY.
// Build macro UPDOWN_COUNTER_SAT_EN selects saturating instead of wrapping counts.
module updown_counter
   import cpu_pkg::*;
#(
   parameter int unsigned     DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter longint unsigned MAX_VALUE  = (64'(1) << DATA_WIDTH) - 64'(1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  OE,
   input  logic                  CS,
   input  logic                  EN,
   input  logic                  CNT_EN,
   input  logic                  UP,
   inout  wire  [DATA_WIDTH-1:0] data,
   output logic                  CARRY,
   output logic                  ZERO
);

   if (!max_value_ok(DATA_WIDTH, MAX_VALUE)) begin : g_bad_max_value
      $error("updown_counter: MAX_VALUE must be below 2**DATA_WIDTH");
   end

   logic [DATA_WIDTH-1:0] count;
   logic [DATA_WIDTH-1:0] count_next;
   logic                  carry_c;
   logic                  load;
   logic                  drive;

   assign load  = EN & CS;
   // Loading takes the bus, so the counter never drives during a load.
   assign drive = OE & CS & ~EN;

   updown_next #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_VALUE  (MAX_VALUE)
   ) u_next (
      .count   (count),
      .up      (UP),
      .cnt_en  (CNT_EN),
      .next_c  (count_next),
      .carry_c (carry_c)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= data;
      end else begin
         count <= count_next;
      end
   end

   assign data  = drive ? count : 'z;
   assign CARRY = carry_c;
   assign ZERO  = (count == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: directed vector table, cascade sequence
// and randomized traffic against a behavioural model of the counting rules.
module tb_updown_counter;

`ifdef UPDOWN_COUNTER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Single counter, modulus 10
   logic       reset, cs, en, oe, cnt_en, up;
   logic [7:0] drv;
   logic       drv_on;
   wire  [7:0] bus;
   wire        carry, zero;
   assign bus = drv_on ? drv : 'z;

   updown_counter #(.DATA_WIDTH(8), .MAX_VALUE(9)) u_dut (
      .clk(clk), .reset(reset), .OE(oe), .CS(cs), .EN(en), .CNT_EN(cnt_en),
      .UP(up), .data(bus), .CARRY(carry), .ZERO(zero)
   );

   // Two full-range stages chained into a 16-bit counter
   logic        c_reset, c_cs, c_en, c_oe, c_cnt_en, c_up;
   logic [15:0] c_drv;
   logic        c_drv_on;
   wire  [7:0]  bus_lo, bus_hi;
   wire         carry_lo, carry_hi, zero_lo, zero_hi;
   assign bus_lo = c_drv_on ? c_drv[7:0]  : 'z;
   assign bus_hi = c_drv_on ? c_drv[15:8] : 'z;

   updown_counter #(.DATA_WIDTH(8)) u_lo (
      .clk(clk), .reset(c_reset), .OE(c_oe), .CS(c_cs), .EN(c_en), .CNT_EN(c_cnt_en),
      .UP(c_up), .data(bus_lo), .CARRY(carry_lo), .ZERO(zero_lo)
   );
   updown_counter #(.DATA_WIDTH(8)) u_hi (
      .clk(clk), .reset(c_reset), .OE(c_oe), .CS(c_cs), .EN(c_en), .CNT_EN(carry_lo),
      .UP(c_up), .data(bus_hi), .CARRY(carry_hi), .ZERO(zero_hi)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural counting rules
   function automatic int model_step(input int c, input bit u, input int max_v);
      if (u) begin
         if (c >= max_v) return SAT ? c : 0;
         return c + 1;
      end
      if (c == 0) return SAT ? 0 : max_v;
      return c - 1;
   endfunction

   function automatic bit model_carry(input int c, input bit ce, input bit u, input int max_v);
      return ce && (u ? (c >= max_v) : (c == 0));
   endfunction

   // The bench drives the bus whenever the counter must not, so stray drive shows up.
   task automatic apply(input bit r, input bit c, input bit e, input bit o,
                        input bit ce, input bit u, input logic [7:0] d);
      reset = r; cs = c; en = e; oe = o; cnt_en = ce; up = u; drv = d;
      drv_on = !(o && c && !e);
   endtask

   task automatic capply(input bit r, input bit c, input bit e, input bit o,
                         input bit ce, input bit u, input logic [15:0] d);
      c_reset = r; c_cs = c; c_en = e; c_oe = o; c_cnt_en = ce; c_up = u; c_drv = d;
      c_drv_on = !(o && c && !e);
   endtask

   typedef struct {
      bit         rst, cs, en, oe, ce, up;
      logic [7:0] din;
      bit         carry;   // CARRY before the edge
      logic [7:0] cnt;     // count after the edge
   } vec_t;

   vec_t vec [16];

   initial begin
      int m, lo, hi;
      bit r, c, e, o, ce, u, cl;
      logic [7:0]  d;
      logic [15:0] d16;

      vec = '{
         '{0,1,1,0,0,1, 8'h5A, 1'b0, 8'h5A},
         '{1,1,1,0,1,1, 8'h33, 1'b1, 8'h00},
         '{0,1,1,0,0,0, 8'h3C, 1'b0, 8'h3C},
         '{0,0,0,0,0,1, 8'h00, 1'b0, 8'h3C},
         '{0,0,1,1,0,1, 8'h55, 1'b0, 8'h3C},
         '{0,1,1,0,0,1, 8'h08, 1'b0, 8'h08},
         '{0,0,0,0,1,1, 8'h00, 1'b0, 8'h09},
         '{0,0,0,0,1,1, 8'h00, 1'b1, SAT ? 8'h09 : 8'h00},
         '{0,0,0,0,1,1, 8'h00, SAT,  SAT ? 8'h09 : 8'h01},
         '{0,1,1,0,0,1, 8'h01, 1'b0, 8'h01},
         '{0,0,0,0,1,0, 8'h00, 1'b0, 8'h00},
         '{0,0,0,0,1,0, 8'h00, 1'b1, SAT ? 8'h00 : 8'h09},
         '{0,0,0,0,1,0, 8'h00, SAT,  SAT ? 8'h00 : 8'h08},
         '{0,1,1,1,1,1, 8'h77, 1'b0, 8'h77},
         '{0,1,1,0,0,1, 8'hF0, 1'b0, 8'hF0},
         '{0,0,0,0,1,1, 8'h00, 1'b1, SAT ? 8'hF0 : 8'h00}
      };

      apply(1,0,0,0,0,0, 8'h00);
      capply(1,0,0,0,0,0, 16'h0000);

      // Reset state: held in reset, CARRY = CNT_EN & ~UP, bus undriven with OE low
      @(negedge clk);
      apply(1,0,0,0,1,0, 8'hA5);
      #1;
      chk("reset_zero", 16'(zero), 16'(1));
      chk("reset_carry", 16'(carry), 16'(1));
      chk("reset_bus_undriven", 16'(bus), 16'h00A5);

      // Directed vectors, each followed by a hold-and-read cycle
      foreach (vec[i]) begin
         @(negedge clk);
         apply(vec[i].rst, vec[i].cs, vec[i].en, vec[i].oe, vec[i].ce, vec[i].up, vec[i].din);
         #1;
         chk($sformatf("vec%0d_carry", i), 16'(carry), 16'(vec[i].carry));
         chk($sformatf("vec%0d_bus_undriven", i), 16'(bus), 16'(vec[i].din));
         @(negedge clk);
         apply(0,1,0,1,0,1, 8'h00);
         #1;
         chk($sformatf("vec%0d_read", i), 16'(bus), 16'(vec[i].cnt));
         chk($sformatf("vec%0d_zero", i), 16'(zero), 16'(vec[i].cnt == 8'h00));
      end

      // Cascade: 0x00FF up one, then down one
      @(negedge clk);
      capply(0,1,1,0,0,1, 16'h00FF);
      @(negedge clk);
      capply(0,0,0,0,1,1, 16'h0000);
      #1;
      chk("casc_up_carry_lo", 16'(carry_lo), 16'(1));
      @(negedge clk);
      capply(0,1,0,1,0,1, 16'h0000);
      #1;
      chk("casc_up_read", {bus_hi, bus_lo}, SAT ? 16'h01FF : 16'h0100);
      @(negedge clk);
      capply(0,0,0,0,1,0, 16'h0000);
      #1;
      chk("casc_down_carry_lo", 16'(carry_lo), SAT ? 16'(0) : 16'(1));
      @(negedge clk);
      capply(0,1,0,1,0,1, 16'h0000);
      #1;
      chk("casc_down_read", {bus_hi, bus_lo}, SAT ? 16'h01FE : 16'h00FF);

      // Randomized traffic on the modulus-10 counter
      m = 0;
      for (int k = 0; k < 600; k++) begin
         r  = (k == 0) || ($urandom_range(99) < 4);
         c  = $urandom_range(99) < 75;
         e  = $urandom_range(99) < 20;
         o  = $urandom_range(99) < 50;
         ce = $urandom_range(99) < 75;
         u  = 1'($urandom_range(1));
         d  = ($urandom_range(99) < 70) ? 8'($urandom_range(12)) : 8'($urandom_range(255));
         @(negedge clk);
         apply(r, c, e, o, ce, u, d);
         #1;
         if (!r || k > 0) begin
            if (k > 0) begin
               chk("rnd_carry", 16'(carry), 16'(model_carry(m, ce, u, 9)));
               chk("rnd_zero", 16'(zero), 16'(m == 0));
               if (o && c && !e) chk("rnd_read", 16'(bus), 16'(m));
               else              chk("rnd_bus_undriven", 16'(bus), 16'(d));
            end
         end
         if (r)           m = 0;
         else if (e && c) m = int'(d);
         else if (ce)     m = model_step(m, u, 9);
      end

      // Randomized traffic on the cascade, modelled stage by stage
      lo = 0; hi = 0;
      for (int k = 0; k < 600; k++) begin
         r  = (k == 0) || ($urandom_range(99) < 3);
         c  = $urandom_range(99) < 75;
         e  = $urandom_range(99) < 15;
         o  = $urandom_range(99) < 50;
         ce = $urandom_range(99) < 80;
         u  = 1'($urandom_range(1));
         case ($urandom_range(3))
            0:       d16 = {8'($urandom_range(255)), 8'hFF};
            1:       d16 = {8'($urandom_range(255)), 8'h00};
            default: d16 = 16'($urandom_range(65535));
         endcase
         @(negedge clk);
         capply(r, c, e, o, ce, u, d16);
         #1;
         cl = model_carry(lo, ce, u, 255);
         if (k > 0) begin
            chk("crnd_carry_lo", 16'(carry_lo), 16'(cl));
            chk("crnd_carry_hi", 16'(carry_hi), 16'(model_carry(hi, cl, u, 255)));
            chk("crnd_zero", 16'({zero_hi, zero_lo}), 16'({hi == 0, lo == 0}));
            if (o && c && !e) chk("crnd_read", {bus_hi, bus_lo}, 16'((hi << 8) | lo));
            else              chk("crnd_bus_undriven", {bus_hi, bus_lo}, d16);
         end
         if (r) begin
            lo = 0; hi = 0;
         end else if (e && c) begin
            lo = int'(d16[7:0]); hi = int'(d16[15:8]);
         end else if (ce) begin
            lo = model_step(lo, u, 255);
            if (cl) hi = model_step(hi, u, 255);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Parametrised successor of the 8-bit up-only bus counter. Loadable, bidirectional (up/down) counter with a programmable modulus and a cascadable terminal-count output. Hangs on the shared tristate data bus: the bus loads it (EN & CS) and reads it back (OE & CS). Used as a program counter, loop counter, or stack pointer; wider counts chain through CARRY into CNT_EN.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), width of count register and data bus
MAX_VALUE, {DATA_WIDTH{1'b1}}, top of count range; counts span 0..MAX_VALUE inclusive

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
OE  input  1  output enable; drives count onto data when OE & CS
CS  input  1  chip select; qualifies OE and EN
EN  input  1  load enable; data captured into count when EN & CS
CNT_EN  input  1  count enable / cascade carry-in
UP  input  1  direction: 1 = increment, 0 = decrement
data  inout  DATA_WIDTH  shared tristate bus
CARRY  output  1  terminal count, combinational, feeds next stage CNT_EN
ZERO  output  1  count == 0, combinational from register

Behaviour:
- Reset: synchronous, active-high. When reset is high at a rising edge, count = 0. Reset overrides load and count.
- Reset values of outputs: ZERO = 1. CARRY = CNT_EN & ~UP. data = Z unless OE & CS.
- Priority at each edge: reset > load > count > hold.
- Load (EN & CS): count <= data at the edge, in 1 cycle, regardless of CNT_EN/UP. A loaded value above MAX_VALUE is accepted as-is.
- Count (CNT_EN, no load):
  - UP = 1: if count >= MAX_VALUE then count <= 0, else count + 1.
  - UP = 0: if count == 0 then count <= MAX_VALUE, else count - 1.
- Hold: the register keeps its value otherwise.
- CARRY = CNT_EN & (UP ? count >= MAX_VALUE : count == 0).
  - Purely combinational, no register.
  - Asserted during the cycle that wraps, so a chained stage steps on the same edge.
- Bus drive:
  - data = count when OE & CS & ~EN.
  - data = Z otherwise.
  - Load wins: the counter never drives while loading, so there is no bus contention.
- Read latency: data and ZERO reflect the new count in the cycle after the edge.
- Width rules: all arithmetic is modulo 2^DATA_WIDTH, then range-checked against MAX_VALUE. MAX_VALUE must be < 2^DATA_WIDTH; elaboration fails otherwise.
- Simultaneous load + count: load wins. CARRY still evaluates from the current count, so cascaded stages must load together.
- Reset mid-count or mid-load: count is 0 the next cycle. No partial state.

Optional Feature:
Macro UPDOWN_COUNTER_SAT_EN.
- Defined: saturating mode. Counting up at count >= MAX_VALUE holds the value. Counting down at 0 holds 0. CARRY still asserts under the same condition, as an overflow/underflow flag.
- Undefined: wrap-around as in Behaviour.
- Load, reset and bus behaviour are identical in both builds.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_WIDTH default
  - direction encodings DIR_UP = 1, DIR_DOWN = 0
  - helper function for MAX_VALUE range check
- One natural sub-module: updown_next.
  - Combinational next-count plus terminal-count logic, inputs count/UP/CNT_EN, outputs next/CARRY.
  - Wrap vs saturate selected inside it by UPDOWN_COUNTER_SAT_EN.
- Top level holds the register, load mux and tristate driver.

Test Plan:
- Reset: set count 0x5A, assert reset one edge with EN & CS and CNT_EN high -> count 0x00, ZERO = 1, data Z when OE low.
- Load/readback: drive data 0x3C, EN & CS one cycle, then release bus and OE & CS -> data reads 0x3C. Check data is Z when CS = 0.
- Up wrap, MAX_VALUE = 9: load 8, CNT_EN & UP for 3 edges -> 9, 0, 1. CARRY high only while count = 9. With SAT_EN: 9, 9, 9 and CARRY stays high.
- Down wrap, MAX_VALUE = 9: load 1, CNT_EN, UP = 0 for 3 edges -> 0, 9, 8. CARRY high while count = 0.
- Cascade: two 8-bit instances, low CARRY into high CNT_EN. Load 0x00FF, count up one edge -> 0x0100. Count down one edge -> 0x00FF.
- Priority/contention: EN & CS & OE & CNT_EN together with data 0x77 -> count 0x77, counter never drives the bus. Load 0xF0 with MAX_VALUE = 9 and count up -> 0x00, CARRY high before the edge.
